uart_tx_cfg: RTL and testbench



---
 rtl/uart_tx_cfg.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter. It has a one-entry holding register and a
// valid/ready handshake. Data width, parity mode and stop-bit count are set
// at compile time. Frames go out LSB first. When the holding register is full
// at the end of the last stop bit, the next frame starts with no idle gap.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Even parity is the XOR of the data bits. Odd parity is its complement.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
    logic p;
    p = ^data;
    if (PARITY == 1) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 bit_end_s;
  logic                 load_s;

  assign o_Tx_Ready  = !hold_valid_q && !i_Reset;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

  // Next-state logic: frame sequencing, the holding register handshake, and the registered line level.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    done_d       = 1'b0;
    load_s       = 1'b0;
    serial_d     = 1'b1;
    bit_end_s    = (clk_cnt_q == CNT_LAST);

    if (i_Tx_DV && o_Tx_Ready) begin
      hold_d       = i_Tx_Byte;
      hold_valid_d = 1'b1;
    end else begin
      hold_d       = hold_q;
    end

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (hold_valid_q) begin
          load_s  = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + IDX_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            if (hold_valid_q) begin
              load_s  = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + IDX_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    // Loading the frame frees the holding register, so the next word can be accepted during this frame.
    if (load_s) begin
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
    end else begin
      shift_d      = shift_q;
    end

    case (state_d)
      ST_IDLE:   serial_d = 1'b1;
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = shift_d[bit_cnt_d];
      ST_PARITY: serial_d = parity_bit(shift_d);
      ST_STOP:   serial_d = 1'b1;
      default:   serial_d = 1'b1;
    endcase

    active_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset. A reset mid-frame abandons the frame and discards any held word.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      serial_q     <= 1'b1;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      serial_q     <= serial_d;
      active_q     <= active_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg. Three configurations share one clock:
// 8N1, 7 data bits with even parity and 2 stop bits, and 7 data bits with odd parity.
module tb_uart_tx_cfg;

  localparam int C = 4;

  logic       clk;
  logic       rst_s   [3];
  logic       dv_s    [3];
  logic [8:0] din_s   [3];
  logic       ready_s [3];
  logic       act_s   [3];
  logic       ser_s   [3];
  logic       done_s  [3];

  int checks_q;
  int errors_q;
  logic [8:0] exp_q [$];

  uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Reset(rst_s[0]), .i_Tx_DV(dv_s[0]), .i_Tx_Byte(din_s[0][7:0]),
    .o_Tx_Ready(ready_s[0]), .o_Tx_Active(act_s[0]), .o_Tx_Serial(ser_s[0]), .o_Tx_Done(done_s[0]));

  uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .i_Clock(clk), .i_Reset(rst_s[1]), .i_Tx_DV(dv_s[1]), .i_Tx_Byte(din_s[1][6:0]),
    .o_Tx_Ready(ready_s[1]), .o_Tx_Active(act_s[1]), .o_Tx_Serial(ser_s[1]), .o_Tx_Done(done_s[1]));

  uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
    .i_Clock(clk), .i_Reset(rst_s[2]), .i_Tx_DV(dv_s[2]), .i_Tx_Byte(din_s[2][6:0]),
    .o_Tx_Ready(ready_s[2]), .o_Tx_Active(act_s[2]), .o_Tx_Serial(ser_s[2]), .o_Tx_Done(done_s[2]));

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_db(input int i);
    if (i == 0) return 8;
    else return 7;
  endfunction

  function automatic int cfg_pa(input int i);
    case (i)
      1: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_sb(input int i);
    if (i == 1) return 2;
    else return 1;
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp_v);
    checks_q = checks_q + 1;
    if (obs != exp_v) begin
      errors_q = errors_q + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Present one word, wait (bounded) for ready, then push it to the scoreboard at its accepting edge.
  task automatic send(input int idx, input logic [8:0] w);
    int n;
    n = 0;
    @(negedge clk);
    dv_s[idx]  = 1'b1;
    din_s[idx] = w;
    while (!ready_s[idx] && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    if (n >= 200) begin
      check_val("ready_timeout", 0, 1);
      dv_s[idx] = 1'b0;
    end else begin
      exp_q.push_back(w);
      @(posedge clk);
      #1;
      dv_s[idx] = 1'b0;
    end
  endtask

  // Decode nfr frames and compare every cycle of every bit against the expected frame.
  task automatic mon(input int idx, input int nfr);
    logic [8:0] w;
    logic       bits [13];
    logic       par;
    int         nb;
    int         wt;
    @(negedge clk);
    for (int f = 0; f < nfr; f++) begin
      wt = 0;
      while (ser_s[idx] !== 1'b0 && wt < 3000) begin
        @(negedge clk);
        wt = wt + 1;
      end
      if (wt >= 3000) begin
        check_val("start_timeout", 0, 1);
        return;
      end
      if (exp_q.size() == 0) begin
        check_val("unexpected_frame", 1, 0);
        return;
      end
      w  = exp_q.pop_front();
      nb = 0;
      bits[nb] = 1'b0;
      nb = nb + 1;
      par = 1'b0;
      for (int d = 0; d < cfg_db(idx); d++) begin
        bits[nb] = w[d];
        nb = nb + 1;
        par = par ^ w[d];
      end
      if (cfg_pa(idx) != 0) begin
        bits[nb] = (cfg_pa(idx) == 2) ? par : ~par;
        nb = nb + 1;
      end
      for (int s = 0; s < cfg_sb(idx); s++) begin
        bits[nb] = 1'b1;
        nb = nb + 1;
      end
      for (int b = 0; b < nb; b++) begin
        for (int c = 0; c < C; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          check_val("line", int'(ser_s[idx]), int'(bits[b]));
          check_val("active", int'(act_s[idx]), 1);
          if (b != 0 || c != 0) check_val("done_early", int'(done_s[idx]), 0);
        end
      end
      @(negedge clk);
      check_val("done_pulse", int'(done_s[idx]), 1);
      check_val("active_after", int'(act_s[idx]), (exp_q.size() != 0) ? 1 : 0);
    end
  endtask

  // The line must stay idle with no activity and no done pulse.
  task automatic idle_check(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("idle_line", int'(ser_s[idx]), 1);
      check_val("idle_active", int'(act_s[idx]), 0);
      check_val("idle_done", int'(done_s[idx]), 0);
    end
  endtask

  initial begin
    int wt;
    checks_q = 0;
    errors_q = 0;
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b1;
      dv_s[i]  = 1'b0;
      din_s[i] = 9'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val("rst_line", int'(ser_s[i]), 1);
      check_val("rst_active", int'(act_s[i]), 0);
      check_val("rst_done", int'(done_s[i]), 0);
      check_val("rst_ready", int'(ready_s[i]), 0);
      rst_s[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) check_val("ready_after_rst", int'(ready_s[i]), 1);

    // Single 8N1 frame
    fork
      send(0, 9'h0A5);
      mon(0, 1);
    join
    idle_check(0, 12);

    // Back-to-back 0x00 then 0xFF; ready low while the holding register is full
    fork
      begin
        send(0, 9'h000);
        send(0, 9'h0FF);
        check_val("ready_hold_full", int'(ready_s[0]), 0);
      end
      mon(0, 2);
    join
    idle_check(0, 12);

    // A word offered while not ready must be ignored
    fork
      begin
        send(0, 9'h012);
        send(0, 9'h034);
        @(negedge clk);
        check_val("ready_blocked", int'(ready_s[0]), 0);
        dv_s[0]  = 1'b1;
        din_s[0] = 9'h03C;
        @(posedge clk);
        #1;
        dv_s[0] = 1'b0;
      end
      mon(0, 2);
    join
    idle_check(0, 60);

    // 7 data bits, even parity, two stop bits, back-to-back
    fork
      begin
        send(1, 9'h007);
        send(1, 9'h055);
      end
      mon(1, 2);
    join
    idle_check(1, 12);

    // 7 data bits, odd parity
    fork
      send(2, 9'h007);
      mon(2, 1);
    join
    idle_check(2, 12);

    // Reset during data bit 3 while a second word is held
    send(0, 9'h05A);
    send(0, 9'h0C3);
    wt = 0;
    @(negedge clk);
    while (ser_s[0] !== 1'b0 && wt < 200) begin
      @(negedge clk);
      wt = wt + 1;
    end
    check_val("rst_test_start", (wt < 200) ? 1 : 0, 1);
    repeat (4 * C) @(negedge clk);
    rst_s[0] = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_line", int'(ser_s[0]), 1);
    check_val("midrst_active", int'(act_s[0]), 0);
    check_val("midrst_ready", int'(ready_s[0]), 0);
    @(negedge clk);
    rst_s[0] = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_val("ready_post_rst", int'(ready_s[0]), 1);
    idle_check(0, 120);

    $display("Simulation finished: %0d checks, %0d errors", checks_q, errors_q);
    $finish;
  end

endmodule
